// File: rtl/mc_controller.sv
// mc_controller: multicycle Moore control unit for an RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every select and enable of the shared datapath.
// Optional build macro MC_BNE_EN: adds bne support in the branch state
// (taken = funct3[0] ? ~zero : zero). When undefined, only beq is accepted
// and any other branch funct3 is skipped as an illegal instruction.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       taken;

    // State register; reset forces FETCH without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unknown opcodes fall back to FETCH from DECODE
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
`ifdef MC_BNE_EN
                    OP_BRANCH:         state_d = S_BEQ;
`else
                    OP_BRANCH:         state_d = (funct3 == 3'b000) ? S_BEQ : S_FETCH;
`endif
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs: each state drives its own selects, everything else 0
    always_comb begin
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        resultsrc = 2'b00;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            default: begin
                irwrite = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_STORE:  immsrc = 2'b01;
            OP_BRANCH: immsrc = 2'b10;
            OP_JAL:    immsrc = 2'b11;
            default:   immsrc = 2'b00;
        endcase
    end

    // ALU decoder; only R-type with funct7b5 set turns funct3=000 into sub
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b00: alucontrol = 3'b000;
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    // PC write: unconditional updates, or a branch whose condition holds
    always_comb begin
`ifdef MC_BNE_EN
        taken = funct3[0] ? ~zero : zero;
`else
        taken = zero;
`endif
        pcwrite = pcupdate | (branch & taken);
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: per-cycle output vectors for each
// instruction class, reset behaviour and combinational decode paths.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite)
    );

    // {irwrite,pcwrite,regwrite,memwrite,adrsrc,resultsrc,alusrca,alusrcb,alucontrol,immsrc}
    logic [15:0] obs;
    assign obs = {irwrite, pcwrite, regwrite, memwrite, adrsrc, resultsrc,
                  alusrca, alusrcb, alucontrol, immsrc};

    localparam logic [15:0] V_FETCH    = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] V_DECODE   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] V_MEMADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] V_MEMREAD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] V_MEMWB    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] V_MEMWRITE = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] V_EXECUTER = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] V_EXECUTEI = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] V_ALUWB    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] V_JAL      = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] V_BEQ      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00};

    localparam logic [15:0] PCW   = 16'h4000;
    localparam logic [15:0] IMM_S = 16'h0001;
    localparam logic [15:0] IMM_B = 16'h0002;
    localparam logic [15:0] IMM_J = 16'h0003;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        #3;
        checks++;
        if (obs !== V_FETCH) begin
            errors++; $display("FAIL reset_initial got %b required %b", obs, V_FETCH);
        end
        op = 7'b0100011; #1;
        checks++;
        if (obs !== (V_FETCH | IMM_S)) begin
            errors++; $display("FAIL reset_immsrc got %b required %b", obs, V_FETCH | IMM_S);
        end
        @(posedge clk); #2;
        checks++;
        if (obs !== (V_FETCH | IMM_S)) begin
            errors++; $display("FAIL reset_held_edge got %b required %b", obs, V_FETCH | IMM_S);
        end
        @(negedge clk); #2;
        op = 7'b0000011; reset = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (obs !== V_DECODE) begin
            errors++; $display("FAIL reset_release_decode got %b required %b", obs, V_DECODE);
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        checks++;
        if (obs !== V_MEMREAD) begin
            errors++; $display("FAIL reset_reach_memread got %b required %b", obs, V_MEMREAD);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== V_FETCH) begin
            errors++; $display("FAIL reset_mid_memread got %b required %b", obs, V_FETCH);
        end
        checks++;
        if ({irwrite, memwrite, regwrite} !== 3'b100) begin
            errors++; $display("FAIL reset_mid_enables got %b required 100", {irwrite, memwrite, regwrite});
        end
        @(negedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (obs !== V_DECODE) begin
            errors++; $display("FAIL reset_second_release got %b required %b", obs, V_DECODE);
        end
        reset = 1'b1; #1;
        reset = 1'b0; #1;
    endtask

    task automatic test_lw();
        logic [15:0] exp [6];
        exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, V_FETCH};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL lw cycle %0d got %b required %b", i, obs, exp[i]);
            end
            if (i < 5) begin @(posedge clk); #2; end
        end
    endtask

    task automatic test_sw();
        logic [15:0] exp [5];
        exp = '{V_FETCH | IMM_S, V_DECODE | IMM_S, V_MEMADR | IMM_S,
                V_MEMWRITE | IMM_S, V_FETCH | IMM_S};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL sw cycle %0d got %b required %b", i, obs, exp[i]);
            end
            if (i < 4) begin @(posedge clk); #2; end
        end
    endtask

    task automatic test_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [2:0] alu, input string name);
        logic [15:0] exe;
        logic [15:0] exp [5];
        exe = (o[5] ? V_EXECUTER : V_EXECUTEI) | {11'b0, alu, 2'b00};
        exp = '{V_FETCH, V_DECODE, exe, V_ALUWB, V_FETCH};
        op = o; funct3 = f3; funct7b5 = f7; zero = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL %s cycle %0d got %b required %b", name, i, obs, exp[i]);
            end
            if (i < 4) begin @(posedge clk); #2; end
        end
    endtask

    task automatic test_jal();
        logic [15:0] exp [5];
        exp = '{V_FETCH | IMM_J, V_DECODE | IMM_J, V_JAL | IMM_J, V_ALUWB | IMM_J, V_FETCH | IMM_J};
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL jal cycle %0d got %b required %b", i, obs, exp[i]);
            end
            if (i < 4) begin @(posedge clk); #2; end
        end
    endtask

    task automatic test_beq(input logic z);
        logic [15:0] exp [4];
        exp = '{V_FETCH | IMM_B, V_DECODE | IMM_B, V_BEQ | IMM_B | (z ? PCW : 16'h0000), V_FETCH | IMM_B};
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL beq_z%0d cycle %0d got %b required %b", z, i, obs, exp[i]);
            end
            if (i == 2) begin
                zero = ~z; #1;
                checks++;
                if (pcwrite !== ~z) begin
                    errors++; $display("FAIL beq_zero_follow got %b required %b", pcwrite, ~z);
                end
                zero = z;
            end
            if (i < 3) begin @(posedge clk); #2; end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp [3];
        exp = '{V_FETCH, V_DECODE, V_FETCH};
        op = 7'b1110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL ecall cycle %0d got %b required %b", i, obs, exp[i]);
            end
            if (i < 2) begin @(posedge clk); #2; end
        end
    endtask

    task automatic test_bne();
`ifdef MC_BNE_EN
        logic [15:0] exp [4];
        exp = '{V_FETCH | IMM_B, V_DECODE | IMM_B, V_BEQ | IMM_B | PCW, V_FETCH | IMM_B};
        op = 7'b1100011; funct3 = 3'b001; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL bne cycle %0d got %b required %b", i, obs, exp[i]);
            end
            if (i < 3) begin @(posedge clk); #2; end
        end
`else
        logic [15:0] exp [3];
        exp = '{V_FETCH | IMM_B, V_DECODE | IMM_B, V_FETCH | IMM_B};
        op = 7'b1100011; funct3 = 3'b001; funct7b5 = 1'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL bne_illegal cycle %0d got %b required %b", i, obs, exp[i]);
            end
            if (i < 2) begin @(posedge clk); #2; end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu(7'b0110011, 3'b000, 1'b1, 3'b001, "r_sub");
        test_alu(7'b0010011, 3'b000, 1'b1, 3'b000, "addi_f7");
        test_alu(7'b0110011, 3'b000, 1'b0, 3'b000, "r_add");
        test_alu(7'b0110011, 3'b010, 1'b0, 3'b101, "r_slt");
        test_alu(7'b0110011, 3'b110, 1'b0, 3'b011, "r_or");
        test_alu(7'b0010011, 3'b111, 1'b0, 3'b010, "andi");
        test_alu(7'b0010011, 3'b001, 1'b1, 3'b000, "i_other");
        test_jal();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_bne();
        test_lw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
